writeback_regfile: RTL and testbench

//  Y86-64 register file plus write-back stage: the write side of the register file the decode stage reads.

---
 rtl/writeback_regfile.sv | 107 ++++++++++
 tb/tb_writeback_regfile.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - Y86-64 write-back stage and register file with one combinational read port.
// Optional same-cycle read bypass of the accepted write: define WB_FORWARD_EN.
module writeback_regfile #(
  parameter int DATA_W  = 64,
  parameter int NREG    = 15,
  parameter int RSP_IDX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [1:0]        stat,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              halted,
  output logic [31:0]       retired
);

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] NREG_A = 4'(NREG);
  localparam logic [3:0] RSP_A  = 4'(RSP_IDX);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t            state_q, state_d;
  logic              halted_q, halted_d;
  logic              ready_q, ready_d;
  logic [31:0]       retired_q, retired_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic       accept, stop, we_e, we_m;
  logic [3:0] dst_e, dst_m;

  always_comb begin
    dst_e = RNONE;
    case (icode)
      4'h2:                      dst_e = cnd ? rB : RNONE;
      4'h3, 4'h6:                dst_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB:    dst_e = RSP_A;
      default:                   dst_e = RNONE;
    endcase
    dst_m = (icode == 4'h5 || icode == 4'hB) ? rA : RNONE;
  end

  assign accept = wb_valid & ready_q;
  // A halting or faulting instruction retires but never writes.
  assign stop   = (icode == 4'h0) || (stat != 2'd0);
  assign we_m   = accept & ~stop & (dst_m != RNONE) & (dst_m < NREG_A);
  // popq %rsp: the loaded value wins over the incremented stack pointer.
  assign we_e   = accept & ~stop & (dst_e != RNONE) & (dst_e < NREG_A) &
                  ~(we_m & (dst_m == dst_e));

  always_comb begin
    regs_d    = regs_q;
    state_d   = state_q;
    retired_d = retired_q;
    if (we_e) regs_d[dst_e] = valE;
    if (we_m) regs_d[dst_m] = valM;
    if (accept) begin
      retired_d = retired_q + 32'd1;
      if (stop) state_d = ST_HALT;
    end
    halted_d = (state_d == ST_HALT);
    ready_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      halted_q  <= 1'b0;
      ready_q   <= 1'b1;
      retired_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= DATA_W'(i);
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      ready_q   <= ready_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr < NREG_A) begin
`ifdef WB_FORWARD_EN
      if (we_m && rd_addr == dst_m)      rd_data = valM;
      else if (we_e && rd_addr == dst_e) rd_data = valE;
      else                               rd_data = regs_q[rd_addr];
`else
      rd_data = regs_q[rd_addr];
`endif
    end
  end

  assign wb_ready = ready_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - scoreboard bench for writeback_regfile against an architectural register model.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [3:0]  icode = '0, rA = '0, rB = '0, rd_addr = '0;
  logic        cnd = 1'b0;
  logic [63:0] valE = '0, valM = '0, rd_data;
  logic [1:0]  stat = '0;
  logic        halted;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  writeback_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .icode(icode), .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
    .stat(stat), .rd_addr(rd_addr), .rd_data(rd_data), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] rd;
    logic        rdy;
    logic        hlt;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];

  // Architectural state of the machine as the program sees it.
  logic [63:0] m_reg [15];
  logic        m_halted;
  logic [31:0] m_retired;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = 64'(i);
    m_halted  = 1'b0;
    m_retired = '0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                            input logic [3:0] rb, input logic c, input logic [63:0] ve,
                            input logic [63:0] vm, input logic [1:0] st);
    int de, dm;
    if (!v || m_halted) return;
    m_retired++;
    if (ic == 4'h0 || st != 2'd0) begin
      m_halted = 1'b1;
      return;
    end
    de = 15;
    dm = 15;
    case (ic)
      4'h2: if (c) de = int'(rb);
      4'h3, 4'h6: de = int'(rb);
      4'h8, 4'h9, 4'hA, 4'hB: de = 4;
      default: de = 15;
    endcase
    if (ic == 4'h5 || ic == 4'hB) dm = int'(ra);
    if (de < 15) m_reg[de] = ve;
    if (dm < 15) m_reg[dm] = vm;
  endtask

  task automatic issue(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic c, input logic [63:0] ve,
                       input logic [63:0] vm, input logic [1:0] st, input logic [3:0] ra_rd);
    exp_t e;
    @(posedge clk);
    #2;
    wb_valid = v; icode = ic; rA = ra; rB = rb; cnd = c;
    valE = ve; valM = vm; stat = st; rd_addr = ra_rd;
    e.addr = ra_rd;
    e.rdy  = ~m_halted;
    e.hlt  = m_halted;
    e.ret  = m_retired;
    e.rd   = (ra_rd < 4'd15) ? m_reg[ra_rd] : 64'd0;
    model_step(v, ic, ra, rb, c, ve, vm, st);
`ifdef WB_FORWARD_EN
    e.rd   = (ra_rd < 4'd15) ? m_reg[ra_rd] : 64'd0;
`endif
    sb.push_back(e);
  endtask

  task automatic idle(input logic [3:0] a);
    issue(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 2'd0, a);
  endtask

  // Reset is asserted between clock edges; its effect is checked before any edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    wb_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #0.5;
      chk($sformatf("reset_reg%0d", i), rd_data, (i < 15) ? 64'(i) : 64'd0);
    end
    chk("reset_retired", 64'(retired), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_ready", 64'(wb_ready), 64'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("rd_data[%0d]", e.addr), rd_data, e.rd);
      chk("wb_ready", 64'(wb_ready), 64'(e.rdy));
      chk("halted", 64'(halted), 64'(e.hlt));
      chk("retired", 64'(retired), 64'(e.ret));
    end
  end

  initial begin
    logic [3:0] ic;
    logic [1:0] st;
    model_reset();
    do_reset();

    // OPq, cmovxx not taken / taken
    issue(1'b1, 4'h6, 4'hF, 4'h3, 1'b0, 64'h55, 64'h0, 2'd0, 4'h3);
    idle(4'h3);
    issue(1'b1, 4'h2, 4'hF, 4'h7, 1'b0, 64'h9, 64'h0, 2'd0, 4'h7);
    idle(4'h7);
    issue(1'b1, 4'h2, 4'hF, 4'h7, 1'b1, 64'h9, 64'h0, 2'd0, 4'h7);
    idle(4'h7);
    // popq %rsp then popq %rdx
    issue(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h200, 2'd0, 4'h4);
    idle(4'h4);
    issue(1'b1, 4'hB, 4'h2, 4'hF, 1'b0, 64'h108, 64'h300, 2'd0, 4'h2);
    idle(4'h4);
    idle(4'h2);
    // halt, then an instruction presented while halted
    issue(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0, 4'h1);
    issue(1'b1, 4'h6, 4'hF, 4'h1, 1'b0, 64'hDEAD, 64'h0, 2'd0, 4'h1);
    idle(4'h1);
    do_reset();
    // exception path
    issue(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'hBEEF, 64'h0, 2'd2, 4'h5);
    idle(4'h5);
    issue(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'hBEEF, 64'h0, 2'd0, 4'h5);
    idle(4'h5);
    do_reset();

    for (int blk = 0; blk < 5; blk++) begin
      for (int n = 0; n < 60; n++) begin
        ic = 4'($urandom_range(0, 15));
        if (ic == 4'h0 && $urandom_range(0, 29) != 0) ic = 4'h6;
        st = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        issue(1'($urandom_range(0, 3) != 0), ic, 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom}, st, 4'($urandom_range(0, 15)));
      end
      do_reset();
    end

    idle(4'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
